// File: rtl/pattern_generator_pkg.sv
// Shared definitions for the pattern generator: default geometry and the
// playback FSM state type.
package pattern_generator_pkg;

  localparam int PATGEN_DEFAULT_CHANNELS  = 10;
  localparam int PATGEN_DEFAULT_DEPTH     = 64;
  localparam int PATGEN_DEFAULT_DIV_WIDTH = 32;

  typedef enum logic {
    PATGEN_IDLE = 1'b0,
    PATGEN_RUN  = 1'b1
  } patgen_state_e;

endpackage

// File: rtl/pattern_generator_if.sv
// Control/pattern bus of the pattern generator. The master side programs the
// pattern table and playback, the slave side is the generator itself.
// chan_mask only exists when PATGEN_CHAN_MASK_EN is defined.
interface pattern_generator_if
  import pattern_generator_pkg::*;
#(
  parameter int CHANNEL_COUNT = PATGEN_DEFAULT_CHANNELS,
  parameter int PATTERN_DEPTH = PATGEN_DEFAULT_DEPTH,
  parameter int DIV_WIDTH     = PATGEN_DEFAULT_DIV_WIDTH
) ();

  localparam int AW = $clog2(PATTERN_DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [CHANNEL_COUNT-1:0] wr_data;
  logic [AW:0]              length;
  logic [DIV_WIDTH-1:0]     rate_div;
  logic                     loop;
  logic                     start;
  logic                     stop;
`ifdef PATGEN_CHAN_MASK_EN
  logic [CHANNEL_COUNT-1:0] chan_mask;
`endif
  logic [CHANNEL_COUNT-1:0] chan_out;
  logic                     sync_out;
  logic                     step_strobe;
  logic                     busy;
  logic                     done;

  modport master (
    output wr_en, wr_addr, wr_data, length, rate_div, loop, start, stop,
`ifdef PATGEN_CHAN_MASK_EN
    output chan_mask,
`endif
    input  chan_out, sync_out, step_strobe, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, length, rate_div, loop, start, stop,
`ifdef PATGEN_CHAN_MASK_EN
    input  chan_mask,
`endif
    output chan_out, sync_out, step_strobe, busy, done
  );

endinterface

// File: rtl/pattern_generator_step_rate_divider.sv
// Step-rate divider: a down-counter that emits a one-clock tick every
// rate_i+1 enabled clocks. It reloads rate_i on load_i and on every tick.
module pattern_generator_step_rate_divider
  import pattern_generator_pkg::*;
#(
  parameter int DIV_WIDTH = PATGEN_DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] rate_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  // Next count: reload on load or tick, otherwise count down while enabled.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (load_i || tick_o) begin
      cnt_d = rate_i;
    end else if (en_i) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Multi-channel pattern source: plays a stored table of CHANNEL_COUNT-bit
// words onto chan_out at a programmable step rate, one-shot or looped.
// sync_out marks presentation of word 0, step_strobe every new word.
// Define PATGEN_CHAN_MASK_EN to add chan_mask, ANDed into chan_out ahead of
// the output register.
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int CHANNEL_COUNT = PATGEN_DEFAULT_CHANNELS,
  parameter int PATTERN_DEPTH = PATGEN_DEFAULT_DEPTH,
  parameter int DIV_WIDTH     = PATGEN_DEFAULT_DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  pattern_generator_if.slave bus
);

  localparam int AW = $clog2(PATTERN_DEPTH);
  localparam int LW = AW + 1;

  typedef logic [CHANNEL_COUNT-1:0] word_t;

  word_t mem [PATTERN_DEPTH];

  patgen_state_e        state_q, state_d;
  logic                 first_q, first_d;   // word 0 goes out on the next edge
  logic [LW-1:0]        idx_q, idx_d;       // count of words presented this pass
  logic [LW-1:0]        len_q, len_d;
  logic                 loop_q, loop_d;
  logic [DIV_WIDTH-1:0] rate_q, rate_d;
  word_t                word_q, word_d;     // unmasked word currently shown
  logic                 sync_q, sync_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 present;
  logic [AW-1:0]        rd_idx;
  logic                 mem_we;
  logic                 div_en;
  logic                 tick;

  assign div_en = (state_q == PATGEN_RUN) && !first_q;

  pattern_generator_step_rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (present),
    .en_i    (div_en),
    .rate_i  (rate_q),
    .tick_o  (tick)
  );

  // Playback FSM: start/stop/wrap decisions and the word to present next.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    idx_d    = idx_q;
    len_d    = len_q;
    loop_d   = loop_q;
    rate_d   = rate_q;
    busy_d   = busy_q;
    sync_d   = 1'b0;
    done_d   = 1'b0;
    present  = 1'b0;
    rd_idx   = idx_q[AW-1:0];
    mem_we   = 1'b0;

    case (state_q)
      PATGEN_IDLE: begin
        mem_we = bus.wr_en;
        if (bus.start && !bus.stop && (bus.length != '0)) begin
          state_d = PATGEN_RUN;
          first_d = 1'b1;
          idx_d   = '0;
          len_d   = (bus.length > LW'(PATTERN_DEPTH)) ? LW'(PATTERN_DEPTH) : bus.length;
          rate_d  = bus.rate_div;
          loop_d  = bus.loop;
        end
      end
      PATGEN_RUN: begin
        if (bus.stop) begin
          // Abort: hold the current word, abandon any pending step.
          state_d = PATGEN_IDLE;
          first_d = 1'b0;
          busy_d  = 1'b0;
        end else if (first_q) begin
          present = 1'b1;
          rd_idx  = '0;
          idx_d   = LW'(1);
          first_d = 1'b0;
          sync_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (tick) begin
          if (idx_q == len_q) begin
            if (loop_q) begin
              present = 1'b1;
              rd_idx  = '0;
              idx_d   = LW'(1);
              sync_d  = 1'b1;
            end else begin
              state_d = PATGEN_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            present = 1'b1;
            idx_d   = idx_q + LW'(1);
          end
        end
      end
      default: state_d = PATGEN_IDLE;
    endcase

    strobe_d = present;
    word_d   = present ? mem[rd_idx] : word_q;
  end

  // Pattern table: synchronous write, only while idle.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; contents are undefined until written,
    // which keeps it mappable onto RAM.
    if (mem_we) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PATGEN_IDLE;
      first_q  <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      rate_q   <= '0;
      word_q   <= '0;
      sync_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      rate_q   <= rate_d;
      word_q   <= word_d;
      sync_q   <= sync_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef PATGEN_CHAN_MASK_EN
  word_t chan_q;

  // Masked output register, refreshed every clock so mask changes show
  // one clock later even while a word is being held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q <= '0;
    end else begin
      chan_q <= word_d & bus.chan_mask;
    end
  end

  assign bus.chan_out = chan_q;
`else
  assign bus.chan_out = word_q;
`endif

  assign bus.sync_out    = sync_q;
  assign bus.step_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator. A cycle-indexed reference model
// derives every expected output from step period, length and loop mode.
// Define PATGEN_CHAN_MASK_EN (for bench and RTL) to also exercise chan_mask.
module tb_pattern_generator;

  localparam int CC = 10;
  localparam int PD = 64;
  localparam int DW = 32;
  localparam int AW = $clog2(PD);

  typedef logic [CC-1:0] word_t;
  typedef struct packed {
    word_t chan;
    logic  sync;
    logic  strobe;
    logic  busy;
    logic  done;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pattern_generator_if #(.CHANNEL_COUNT(CC), .PATTERN_DEPTH(PD), .DIV_WIDTH(DW)) bus ();

  pattern_generator #(
    .CHANNEL_COUNT (CC),
    .PATTERN_DEPTH (PD),
    .DIV_WIDTH     (DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  word_t mem_m [PD];
  word_t mask_m = '1;
  word_t held   = '0;
  int    n_checks = 0;
  int    n_fail   = 0;
  obs_t  got, exp;

`ifdef PATGEN_CHAN_MASK_EN
  assign bus.chan_mask = mask_m;
`endif

  function automatic obs_t observe();
    return {bus.chan_out, bus.sync_out, bus.step_strobe, bus.busy, bus.done};
  endfunction

  // Expected outputs t clocks after the start edge (t=1 is the first word).
  function automatic obs_t model(int t, int len, int rate, bit lp);
    obs_t e;
    int p, k, total, s;
    p = rate + 1;
    k = t - 1;
    total = len * p;
    e = '0;
    if (lp || k < total) begin
      s = (k / p) % len;
      e.chan   = mem_m[s] & mask_m;
      e.strobe = (k % p == 0);
      e.sync   = (k % p == 0) && (s == 0);
      e.busy   = 1'b1;
    end else begin
      e.chan = mem_m[len-1] & mask_m;
      e.done = (k == total);
    end
    return e;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.chan = held;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input word_t d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    next_cycle();
    bus.wr_en   = 1'b0;
    mem_m[a]    = d;
  endtask

  task automatic start_run(input int len, input int rate, input bit lp);
    bus.length   = (AW+1)'(len);
    bus.rate_div = DW'(rate);
    bus.loop     = lp;
    bus.start    = 1'b1;
    next_cycle();
    bus.start    = 1'b0;
    bus.wr_en    = 1'b0;
  endtask

  task automatic stop_run();
    bus.stop = 1'b1;
    next_cycle();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.length = '0;
    bus.rate_div = '0; bus.loop = 0; bus.start = 0; bus.stop = 0;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      if (i == 2) reset_n = 1'b1;
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset i=%0d got=%h expected=0", i, got);
      end
    end
    held = '0;
  endtask

  task automatic test_one_shot();
    for (int i = 0; i < 4; i++) write_word(i, word_t'(i));
    start_run(4, 0, 0);
    for (int t = 1; t <= 8; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 0, 0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL one_shot t=%0d got=%h expected=%h", t, got, exp);
      end
    end
    held = exp.chan;
  endtask

  task automatic test_loop_stop();
    start_run(4, 2, 1);
    for (int t = 1; t <= 30; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 2, 1);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL loop t=%0d got=%h expected=%h", t, got, exp);
      end
    end
    held = exp.chan;
    stop_run();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      got = observe(); exp = idle_exp();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL loop_stop i=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_edge_starts();
    // length 0, then start together with stop: neither may begin a run.
    for (int c = 0; c < 2; c++) begin
      if (c == 1) bus.stop = 1'b1;
      start_run((c == 0) ? 0 : 4, 0, 0);
      bus.stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) next_cycle();
        got = observe(); exp = idle_exp();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL no_start case=%0d i=%0d got=%h expected=%h", c, i, got, exp);
        end
      end
    end
    // Oversized length is clamped to the full table, looped and one-shot.
    for (int i = 0; i < PD; i++) write_word(i, word_t'($urandom()));
    for (int c = 0; c < 2; c++) begin
      start_run(100, 0, (c == 0));
      for (int t = 1; t <= ((c == 0) ? 2 * PD + 3 : PD + 3); t++) begin
        next_cycle();
        got = observe(); exp = model(t, PD, 0, (c == 0));
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL clamp loop=%0d t=%0d got=%h expected=%h", c == 0, t, got, exp);
        end
      end
      held = exp.chan;
      if (c == 0) stop_run();
    end
  endtask

  task automatic test_write_rules();
    word_t nw;
    for (int i = 0; i < 4; i++) write_word(i, word_t'($urandom()));
    start_run(4, 1, 1);
    for (int t = 1; t <= 12; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 1, 1);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wr_in_run t=%0d got=%h expected=%h", t, got, exp);
      end
      if (t == 2) begin
        bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = ~mem_m[1];
      end
      if (t == 4) bus.wr_en = 1'b0;
    end
    stop_run();
    // Replay: the RUN-time write must not have landed. Then write+start.
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        nw = ~mem_m[0];
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = nw;
        mem_m[0] = nw;
      end
      start_run(4, 0, 0);
      for (int t = 1; t <= 6; t++) begin
        next_cycle();
        got = observe(); exp = model(t, 4, 0, 0);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL replay case=%0d t=%0d got=%h expected=%h", c, t, got, exp);
        end
      end
    end
    held = exp.chan;
  endtask

  task automatic test_reset_midrun();
    start_run(4, 1, 1);
    for (int t = 1; t <= 5; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 1, 1);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pre_reset t=%0d got=%h expected=%h", t, got, exp);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL async_reset i=%0d got=%h expected=0", i, got);
      end
    end
    reset_n = 1'b1;
    held = '0;
    for (int i = 0; i < 4; i++) write_word(i, word_t'($urandom()));
    start_run(4, 0, 0);
    for (int t = 1; t <= 6; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 0, 0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset t=%0d got=%h expected=%h", t, got, exp);
      end
    end
    held = exp.chan;
  endtask

  task automatic test_random();
    int len, rate, cyc;
    bit lp;
    for (int it = 0; it < 6; it++) begin
      len  = $urandom_range(1, 16);
      rate = $urandom_range(0, 3);
      lp   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) write_word(i, word_t'($urandom()));
      start_run(len, rate, lp);
      cyc = len * (rate + 1) * (lp ? 2 : 1) + 3;
      for (int t = 1; t <= cyc; t++) begin
        next_cycle();
        got = observe(); exp = model(t, len, rate, lp);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random it=%0d len=%0d rate=%0d loop=%0d t=%0d got=%h expected=%h",
                   it, len, rate, lp, t, got, exp);
        end
      end
      held = exp.chan;
      if (lp) stop_run();
    end
  endtask

`ifdef PATGEN_CHAN_MASK_EN
  task automatic test_mask();
    for (int i = 0; i < 4; i++) write_word(i, '1);
    mask_m = word_t'(10'h155);
    start_run(4, 3, 1);
    for (int t = 1; t <= 10; t++) begin
      next_cycle();
      got = observe(); exp = model(t, 4, 3, 1);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mask t=%0d got=%h expected=%h", t, got, exp);
      end
      if (t == 6) mask_m = word_t'(10'h0AA);
    end
    held = exp.chan;
    stop_run();
    mask_m = '1;
    next_cycle();
    held = '1;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_one_shot();
    test_loop_stop();
    test_edge_starts();
    test_write_rules();
    test_reset_midrun();
    test_random();
`ifdef PATGEN_CHAN_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
